// File: rtl/pump_bank_fsm_pkg.sv
// Shared definitions for the pump bank: channel state codes and command codes.
// Imported by the RTL and by the testbench so both agree on the encodings.
package pump_bank_fsm_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_STANDBY = 2'd1,
        ST_WORKING = 2'd2,
        ST_FAULT   = 2'd3
    } pump_state_e;

    typedef enum logic [1:0] {
        CMD_TURN_OFF = 2'd0,
        CMD_TURN_ON  = 2'd1,
        CMD_STOP     = 2'd2,
        CMD_START    = 2'd3
    } pump_cmd_e;

endpackage

// File: rtl/pump_channel.sv
// One pump channel: off/standby/working(/fault) FSM, run watchdog and output registers.
// Watchdog and FAULT handling are built only when PUMP_BANK_WATCHDOG_EN is defined.
module pump_channel
    import pump_bank_fsm_pkg::*;
#(
    parameter int MAX_RUN = 1000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [1:0] command,
    input  logic       blink_phase,
    output logic       pump,
    output logic       led,
    output logic       fault
);

    pump_state_e state_r;
    pump_state_e state_s;
    logic        trip_s;
    logic        pump_s;
    logic        led_s;
    logic        fault_s;

`ifdef PUMP_BANK_WATCHDOG_EN
    localparam int RUN_W = $clog2(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);

    logic [RUN_W-1:0] run_cnt_r;
    logic [RUN_W-1:0] run_cnt_s;

    assign trip_s = (state_r == ST_WORKING) && (run_cnt_r == RUN_LAST);

    // Run counter next value: counts only while staying in WORKING, saturates at the trip value
    always_comb begin
        run_cnt_s = '0;
        if ((state_r == ST_WORKING) && (state_s == ST_WORKING)) begin
            if (run_cnt_r != RUN_LAST) begin
                run_cnt_s = run_cnt_r + RUN_W'(1);
            end else begin
                run_cnt_s = run_cnt_r;
            end
        end else begin
            run_cnt_s = '0;
        end
    end

    // Run counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt_r <= '0;
        end else begin
            run_cnt_r <= run_cnt_s;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = 1'(MAX_RUN);
    assign trip_s       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an explicit stop/off command outranks a watchdog trip on the same edge
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (accept && (command == CMD_TURN_ON)) begin
                    state_s = ST_STANDBY;
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_STANDBY: begin
                if (accept && (command == CMD_START)) begin
                    state_s = ST_WORKING;
                end else if (accept && (command == CMD_TURN_OFF)) begin
                    state_s = ST_OFF;
                end else begin
                    state_s = ST_STANDBY;
                end
            end
            ST_WORKING: begin
                if (accept && (command == CMD_STOP)) begin
                    state_s = ST_STANDBY;
                end else if (accept && (command == CMD_TURN_OFF)) begin
                    state_s = ST_OFF;
                end else if (trip_s) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_WORKING;
                end
            end
            ST_FAULT: begin
                if (accept && (command == CMD_TURN_OFF)) begin
                    state_s = ST_OFF;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_OFF;
            end
        endcase
    end

    // Output decode from the next state so outputs line up with the new state
    always_comb begin
        pump_s  = 1'b0;
        led_s   = 1'b0;
        fault_s = 1'b0;
        case (state_s)
            ST_OFF: begin
                led_s = 1'b0;
            end
            ST_STANDBY: begin
                led_s = 1'b1;
            end
            ST_WORKING: begin
                pump_s = 1'b1;
                led_s  = 1'b1;
            end
            ST_FAULT: begin
                led_s   = blink_phase;
                fault_s = 1'b1;
            end
            default: begin
                led_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pump  <= 1'b0;
            led   <= 1'b0;
            fault <= 1'b0;
        end else begin
            pump  <= pump_s;
            led   <= led_s;
            fault <= fault_s;
        end
    end

endmodule

// File: rtl/pump_bank_fsm.sv
// N-channel pump bank: channel-select decode, shared fault-blink prescaler, per-channel FSMs.
// Optional feature macro: PUMP_BANK_WATCHDOG_EN (run watchdog, FAULT state, blinking fault LED).
module pump_bank_fsm
    import pump_bank_fsm_pkg::*;
#(
    parameter int N_PUMPS    = 4,
    parameter int CH_W       = 2,
    parameter int MAX_RUN    = 1000,
    parameter int BLINK_HALF = 8
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               update,
    input  logic [CH_W-1:0]    channel,
    input  logic [1:0]         command,
    output logic [N_PUMPS-1:0] pump,
    output logic [N_PUMPS-1:0] led,
    output logic [N_PUMPS-1:0] fault
);

    logic [N_PUMPS-1:0] accept_s;
    logic               blink_phase_s;

    // Channel decode; out-of-range channel indices match no instance and are dropped
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < N_PUMPS; i++) begin
            if (update && (int'(channel) == i)) begin
                accept_s[i] = 1'b1;
            end else begin
                accept_s[i] = 1'b0;
            end
        end
    end

`ifdef PUMP_BANK_WATCHDOG_EN
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

    logic [BLK_W-1:0] blink_cnt_r;
    logic [BLK_W-1:0] blink_cnt_s;
    logic             blink_phase_r;

    // Prescaler next value; the next phase feeds the channels so a faulted LED equals the phase register
    always_comb begin
        blink_cnt_s   = '0;
        blink_phase_s = blink_phase_r;
        if (blink_cnt_r == BLK_LAST) begin
            blink_cnt_s   = '0;
            blink_phase_s = ~blink_phase_r;
        end else begin
            blink_cnt_s   = blink_cnt_r + BLK_W'(1);
            blink_phase_s = blink_phase_r;
        end
    end

    // Free-running blink prescaler shared by all channels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else begin
            blink_cnt_r   <= blink_cnt_s;
            blink_phase_r <= blink_phase_s;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s  = 1'(BLINK_HALF);
    assign blink_phase_s = 1'b0;
`endif

    for (genvar g = 0; g < N_PUMPS; g++) begin : g_ch
        pump_channel #(
            .MAX_RUN (MAX_RUN)
        ) u_ch (
            .clk         (clk),
            .rst         (reset),
            .accept      (accept_s[g]),
            .command     (command),
            .blink_phase (blink_phase_s),
            .pump        (pump[g]),
            .led         (led[g]),
            .fault       (fault[g])
        );
    end

endmodule

// File: tb/tb_pump_bank_fsm.sv
// Self-checking bench for pump_bank_fsm: a cycle reference model pushes expected outputs
// into a scoreboard queue at each clock edge; they are popped and compared on the falling edge.
module tb_pump_bank_fsm;
    import pump_bank_fsm_pkg::*;

    localparam int NP    = 3;
    localparam int CHW   = 2;
    localparam int MRUN  = 20;
    localparam int BHALF = 8;
`ifdef PUMP_BANK_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           update;
    logic [CHW-1:0] channel;
    logic [1:0]     command;
    logic [NP-1:0]  pump;
    logic [NP-1:0]  led;
    logic [NP-1:0]  fault;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    pump_state_e m_state [NP] = '{ST_OFF, ST_OFF, ST_OFF};
    int          m_cnt   [NP] = '{0, 0, 0};
    int          m_edges      = 0;
    logic [3*NP-1:0] exp_q [$];

    pump_bank_fsm #(
        .N_PUMPS    (NP),
        .CH_W       (CHW),
        .MAX_RUN    (MRUN),
        .BLINK_HALF (BHALF)
    ) dut (
        .clk     (clk),
        .reset   (rst),
        .update  (update),
        .channel (channel),
        .command (command),
        .pump    (pump),
        .led     (led),
        .fault   (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference next state of one channel, written from the behavioural description
    function automatic pump_state_e ref_next(pump_state_e st, logic acc, logic [1:0] cm, int cnt);
        pump_state_e nx;
        nx = st;
        case (st)
            ST_OFF:     if (acc && cm == CMD_TURN_ON) nx = ST_STANDBY;
            ST_STANDBY: if (acc && cm == CMD_START) nx = ST_WORKING;
                        else if (acc && cm == CMD_TURN_OFF) nx = ST_OFF;
            ST_WORKING: if (acc && cm == CMD_STOP) nx = ST_STANDBY;
                        else if (acc && cm == CMD_TURN_OFF) nx = ST_OFF;
                        else if (WD && cnt >= MRUN - 1) nx = ST_FAULT;
            ST_FAULT:   if (acc && cm == CMD_TURN_OFF) nx = ST_OFF;
            default:    nx = ST_OFF;
        endcase
        return nx;
    endfunction

    function automatic logic [3*NP-1:0] ref_vec(logic ph);
        logic [NP-1:0] p, l, f;
        pump_state_e nx;
        p = '0; l = '0; f = '0;
        for (int c = 0; c < NP; c++) begin
            nx = ref_next(m_state[c], update && (int'(channel) == c), command, m_cnt[c]);
            p[c] = (nx == ST_WORKING);
            l[c] = (nx == ST_STANDBY) || (nx == ST_WORKING) || ((nx == ST_FAULT) && ph);
            f[c] = (nx == ST_FAULT);
        end
        return {p, l, f};
    endfunction

    // Reference model: advance on every edge and queue the outputs the DUT must show next
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NP; c++) begin
                m_state[c] <= ST_OFF;
                m_cnt[c]   <= 0;
            end
            m_edges <= 0;
            exp_q.delete();
        end else begin
            exp_q.push_back(ref_vec(WD && ((((m_edges + 1) / BHALF) % 2) == 1)));
            for (int c = 0; c < NP; c++) begin
                m_state[c] <= ref_next(m_state[c], update && (int'(channel) == c), command, m_cnt[c]);
                m_cnt[c]   <= (m_state[c] == ST_WORKING &&
                               ref_next(m_state[c], update && (int'(channel) == c), command, m_cnt[c]) == ST_WORKING)
                              ? m_cnt[c] + 1 : 0;
            end
            m_edges <= m_edges + 1;
        end
    end

    // Scoreboard: compare DUT outputs against the queued expectation away from the active edge
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            check_value("sb_pump",  32'(pump),  32'(exp_q[0][3*NP-1:2*NP]));
            check_value("sb_led",   32'(led),   32'(exp_q[0][2*NP-1:NP]));
            check_value("sb_fault", 32'(fault), 32'(exp_q[0][NP-1:0]));
            void'(exp_q.pop_front());
            n_pops <= n_pops + 1;
        end
    end

    task automatic step(input logic u, input logic [CHW-1:0] ch, input logic [1:0] cm);
        update  = u;
        channel = ch;
        command = cm;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int   toggles;
        logic prev;
        rst = 1'b1; update = 1'b0; channel = 2'd0; command = 2'd0;
        #8;
        check_value("reset_outputs", {pump, led, fault}, 32'd0);
        #4 rst = 1'b0;
        @(negedge clk);

        // 1: turnOn then startPump on channel 0
        step(1'b1, 2'd0, CMD_TURN_ON);
        check_value("t1_led0", 32'(led[0]), 32'd1);
        check_value("t1_pump0_standby", 32'(pump[0]), 32'd0);
        step(1'b1, 2'd0, CMD_START);
        check_value("t1_pump0", 32'(pump[0]), 32'd1);
        check_value("t1_others", 32'({pump[2:1], led[2:1]}), 32'd0);
        step(1'b1, 2'd0, CMD_TURN_OFF);
        check_value("t1_off", 32'({pump[0], led[0]}), 32'd0);

        // 2: startPump while OFF is ignored, then standby / working / standby
        step(1'b1, 2'd2, CMD_START);
        check_value("t2_ignored", 32'({pump[2], led[2]}), 32'd0);
        step(1'b1, 2'd2, CMD_TURN_ON);
        check_value("t2_standby", 32'({pump[2], led[2]}), 32'b01);
        step(1'b1, 2'd2, CMD_START);
        check_value("t2_working", 32'({pump[2], led[2]}), 32'b11);
        step(1'b1, 2'd2, CMD_TURN_ON);
        check_value("t2_on_ignored", 32'({pump[2], led[2]}), 32'b11);
        step(1'b1, 2'd2, CMD_STOP);
        check_value("t2_stop", 32'({pump[2], led[2]}), 32'b01);
        step(1'b1, 2'd2, CMD_TURN_OFF);

`ifdef PUMP_BANK_WATCHDOG_EN
        // 3: watchdog trip after MAX_RUN working cycles, blinking LED, only turnOff clears
        step(1'b1, 2'd1, CMD_TURN_ON);
        step(1'b1, 2'd1, CMD_START);
        idle(MRUN - 1);
        check_value("t3_before_trip", 32'({pump[1], fault[1]}), 32'b10);
        idle(1);
        check_value("t3_tripped", 32'({pump[1], fault[1]}), 32'b01);
        prev = led[1];
        toggles = 0;
        for (int i = 0; i < 4 * BHALF; i++) begin
            idle(1);
            if (led[1] !== prev) toggles++;
            prev = led[1];
        end
        check_value("t3_blink_toggles", 32'(toggles), 32'd4);
        step(1'b1, 2'd1, CMD_STOP);
        check_value("t3_stop_ignored", 32'(fault[1]), 32'd1);
        step(1'b1, 2'd1, CMD_START);
        check_value("t3_start_ignored", 32'({pump[1], fault[1]}), 32'b01);
        step(1'b1, 2'd1, CMD_TURN_OFF);
        check_value("t3_cleared", 32'({pump[1], led[1], fault[1]}), 32'd0);

        // 4: stopPump on the trip edge wins; restart gives a full run again
        step(1'b1, 2'd1, CMD_TURN_ON);
        step(1'b1, 2'd1, CMD_START);
        idle(MRUN - 1);
        step(1'b1, 2'd1, CMD_STOP);
        check_value("t4_stop_wins", 32'({pump[1], led[1], fault[1]}), 32'b010);
        step(1'b1, 2'd1, CMD_START);
        idle(MRUN - 1);
        check_value("t4_full_run", 32'({pump[1], fault[1]}), 32'b10);
        idle(1);
        check_value("t4_trip_again", 32'({pump[1], fault[1]}), 32'b01);
        step(1'b1, 2'd1, CMD_TURN_OFF);
`else
        // 6: without the watchdog, WORKING persists indefinitely
        step(1'b1, 2'd0, CMD_TURN_ON);
        step(1'b1, 2'd0, CMD_START);
        idle(5000);
        check_value("t6_still_working", 32'({pump[0], fault[0]}), 32'b10);
        step(1'b1, 2'd0, CMD_TURN_OFF);
`endif

        // 5: out-of-range channel has no effect; async reset mid-cycle clears everything
        step(1'b1, 2'd3, CMD_TURN_ON);
        check_value("t5_bad_channel", {pump, led, fault}, 32'd0);
        step(1'b1, 2'd0, CMD_TURN_ON);
        step(1'b1, 2'd0, CMD_START);
        step(1'b1, 2'd2, CMD_TURN_ON);
        step(1'b1, 2'd2, CMD_START);
        step(1'b0, 2'd0, CMD_TURN_OFF);
        check_value("t5_two_working", 32'(pump), 32'b101);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_value("t5_async_reset", {pump, led, fault}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        idle(2);
        check_value("t5_after_reset", {pump, led, fault}, 32'd0);

        check_value("sb_activity", 32'(n_pops > 50), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
